// File: rtl/debug_instr_loader.sv
// Parses framed load packets from the UART byte stream and presents big-endian instruction words with their PC.
// Optional build macro DEBUG_LOADER_CSUM_EN enables the XOR checksum check on the CSUM byte.
module debug_instr_loader #(
    parameter logic [31:0] BASE_PC        = 32'h0000_0000,
    parameter int          MAX_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  START_BYTE     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        instruction_mem_no_op,
    output logic [31:0] instruction_mem_pc,
    output logic [31:0] instruction_mem_instruction,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    // state   | meaning
    // S_IDLE  | waiting for START_BYTE
    // S_LEN_HI| expecting word-count high byte
    // S_LEN_LO| expecting word-count low byte
    // S_DATA  | collecting 4 bytes per word, N words
    // S_CSUM  | expecting checksum byte
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM} state_t;

    localparam int          TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_N  = 17'(MAX_WORDS);

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_len_hi;
    logic [15:0]   r_len;
    logic [15:0]   r_word_idx;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_shift;
    logic [TW-1:0] r_tmo;
    logic          r_no_op;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic          r_done;
    logic          r_err;

    logic [15:0]   w_len;
    logic          w_len_bad;
    logic          w_timeout;
    logic          w_byte;
    logic          w_commit;
    logic          w_done;
    logic          w_err_set;
    logic          w_err_clr;
    logic          w_csum_ok;

    assign w_len     = {r_len_hi, rx_data};
    assign w_len_bad = {1'b0, w_len} > MAX_N;
    assign w_timeout = (r_state != S_IDLE) && (r_tmo == '0);
    // A byte landing in the timeout cycle is dropped, not parsed.
    assign w_byte    = rx_valid && !w_timeout;

`ifdef DEBUG_LOADER_CSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor <= 8'h00;
        end else if (w_byte) begin
            if (r_state == S_IDLE && rx_data == START_BYTE) r_xor <= 8'h00;
            else if (r_state == S_DATA)                     r_xor <= r_xor ^ rx_data;
        end
    end

    assign w_csum_ok = (rx_data == r_xor);
`else
    assign w_csum_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_done      = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_err_set   = 1'b1;
        end else if (rx_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (rx_data == START_BYTE) begin
                        w_state_nxt = S_LEN_HI;
                        w_err_clr   = 1'b1;
                    end
                end
                S_LEN_HI: w_state_nxt = S_LEN_LO;
                S_LEN_LO: begin
                    if (w_len_bad) begin
                        w_state_nxt = S_IDLE;
                        w_err_set   = 1'b1;
                    end else if (w_len == 16'd0) begin
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_byte_idx == 2'd3) begin
                        w_commit = 1'b1;
                        if (r_word_idx == r_len - 16'd1) w_state_nxt = S_CSUM;
                    end
                end
                S_CSUM: begin
                    w_state_nxt = S_IDLE;
                    if (w_csum_ok) w_done    = 1'b1;
                    else           w_err_set = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_hi   <= 8'h00;
            r_len      <= 16'h0000;
            r_word_idx <= 16'h0000;
            r_byte_idx <= 2'd0;
            r_shift    <= 24'h000000;
            r_tmo      <= TW'(TIMEOUT_CYCLES);
            r_no_op    <= 1'b1;
            r_pc       <= 32'h0000_0000;
            r_instr    <= 32'h0000_0000;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_no_op <= 1'b1;
            r_done  <= w_done;
            if (w_err_set)      r_err <= 1'b1;
            else if (w_err_clr) r_err <= 1'b0;

            if (r_state == S_IDLE || rx_valid) r_tmo <= TW'(TIMEOUT_CYCLES);
            else if (r_tmo != '0)              r_tmo <= r_tmo - 1'b1;

            if (w_byte) begin
                case (r_state)
                    S_IDLE: begin
                        r_word_idx <= 16'h0000;
                        r_byte_idx <= 2'd0;
                    end
                    S_LEN_HI: r_len_hi <= rx_data;
                    S_LEN_LO: r_len    <= w_len;
                    S_DATA: begin
                        r_shift    <= {r_shift[15:0], rx_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                    default: ;
                endcase
            end

            if (w_commit) begin
                r_no_op    <= 1'b0;
                r_pc       <= BASE_PC + {14'd0, r_word_idx, 2'b00};
                r_instr    <= {r_shift, rx_data};
                r_word_idx <= r_word_idx + 16'd1;
            end
        end
    end

    assign instruction_mem_no_op       = r_no_op;
    assign instruction_mem_pc          = r_pc;
    assign instruction_mem_instruction = r_instr;
    assign busy                        = (r_state != S_IDLE);
    assign load_done                   = r_done;
    assign load_error                  = r_err;

endmodule

// File: doc/debug_instr_loader.md
Name: debug_instr_loader

Overview:
- Upstream feeder of the debug core's instruction-injection port.
- Takes a byte stream from the UART receive unit and parses framed load packets.
- Assembles big-endian 32-bit instruction words and presents each one with its PC on the pc/instruction/no_op interface consumed by the instruction memory.
- Reports frame completion and errors (length, checksum, inter-byte timeout).

Parameters:
BASE_PC, 32'h0000_0000, PC of first word in every frame
MAX_WORDS, 1024, largest accepted word count per frame
TIMEOUT_CYCLES, 1000000, idle cycles between bytes before a frame aborts
START_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe, rx_data valid
instruction_mem_no_op  output  1  0 = pc/instruction valid this cycle (write), 1 = no write
instruction_mem_pc  output  32  PC of presented word
instruction_mem_instruction  output  32  presented instruction word
busy  output  1  frame in progress
load_done  output  1  one-cycle pulse on successful frame end
load_error  output  1  sticky error flag

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock clk. Reset values: instruction_mem_no_op=1, instruction_mem_pc=0, instruction_mem_instruction=0, busy=0, load_done=0, load_error=0. FSM goes to IDLE; all counters clear.
- Frame format, in order:
  - START_BYTE
  - LEN_HI, then LEN_LO: 16-bit word count N
  - 4*N data bytes, MSB first per word
  - CSUM: XOR of data bytes only
- FSM states and transitions:
  - IDLE: byte == START_BYTE -> LEN_HI, clears load_error; other bytes ignored.
  - LEN_HI -> LEN_LO.
  - LEN_LO -> DATA if N >= 1; CSUM if N == 0; N > MAX_WORDS -> load_error=1, go to IDLE.
  - DATA: byte index 0..3 shifts into word register. On index 3 the word is committed. After word N-1 -> CSUM.
  - CSUM: compare (see Optional Feature). Match -> load_done pulse next cycle, go to IDLE. Mismatch -> load_error=1, go to IDLE.
- busy=1 in every state except IDLE.
- Word commit latency: rx_valid on 4th byte at cycle t -> cycle t+1 drives:
  - instruction_mem_no_op=0 for exactly one cycle
  - instruction_mem_pc = BASE_PC + 4*i, i = word index in frame, mod 2^32
  - instruction_mem_instruction = assembled word
- pc/instruction hold their last values while no_op=1.
- Timeout:
  - Counter clears on each rx_valid and in IDLE.
  - Outside IDLE, reaching TIMEOUT_CYCLES sets load_error=1 and returns to IDLE.
  - A partial word is discarded, never written.
  - Words already written are not retracted.
- rx_valid is accepted every cycle (no backpressure), including back-to-back strobes.
- A byte arriving in the same cycle the timeout fires is dropped.
- load_error stays high until the next START_BYTE is accepted in IDLE, or reset.
- Reset mid-frame: outputs return to reset values at once; no write is emitted for the pending word.

Optional Feature:
- Macro: DEBUG_LOADER_CSUM_EN.
- Defined: running XOR of data bytes (cleared at START) is compared with the CSUM byte; mismatch sets load_error and suppresses load_done.
- Undefined: CSUM byte is consumed and ignored; load_done always pulses after CSUM; XOR logic is absent.

Test Plan:
- Frame A5 00 02 8C 09 00 00 20 08 00 04 A9 -> no_op low twice:
  - pc=0, instr=8C090000
  - pc=4, instr=20080004
  - then load_done pulse; load_error=0.
- Same frame with CSUM 00 (macro defined) -> both writes occur, load_error=1, no load_done; next A5 clears load_error.
- Bytes 11 22 then A5 00 00 55 -> leading bytes ignored, zero writes, load_done pulse with macro off; with macro on, load_error=1 since XOR of no bytes is 00.
- A5 00 01 8C 09, then silence for TIMEOUT_CYCLES (bench sets 16) -> load_error=1, busy=0, no write.
- A5 04 01 -> N=1025 > MAX_WORDS -> load_error=1, FSM IDLE, no writes.
- rst_n pulsed low after 3rd data byte -> all outputs at reset values, no write; a following valid 1-word frame writes at pc=BASE_PC.
